// File: rtl/control_sequencer_if.sv
// Bus between the 8-bit computer's instruction register/flags and the microcode sequencer.
// The slave side (the sequencer) receives step enable, opcode and flags, and drives the step and control lines.
interface control_sequencer_if #(
    parameter int STEP_W = 3
);
    logic              step_en;
    logic [3:0]        opcode;
    logic              cf;
    logic              zf;
    logic [STEP_W-1:0] step;
    logic              hlt;
    logic              halted;   // debug: mode register is HALTED
    logic              co, j, ce;
    logic              mi, ri, ro;
    logic              ii, io;
    logic              ai, ao;
    logic              bi;
    logic              eo, su, fi;
    logic              oi;

    modport master (
        output step_en, opcode, cf, zf,
        input  step, hlt, halted, co, j, ce, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi
    );

    modport slave (
        input  step_en, opcode, cf, zf,
        output step, hlt, halted, co, j, ce, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-state counter plus RUN/HALTED mode, with combinational
// decode of {opcode, step, flags} into the bus control lines.
module control_sequencer #(
    parameter int STEP_W    = 3,
    parameter int LAST_STEP = 4
) (
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.slave  bus
);
    typedef enum logic {RUN, HALTED} mode_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [STEP_W-1:0] S_LAST = STEP_W'(LAST_STEP);
    localparam logic [STEP_W-1:0] S0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] S1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] S2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] S3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] S4 = STEP_W'(4);

    mode_t             mode_q, mode_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] end_step;

    always_comb begin
        end_step = S1;
        unique case (bus.opcode)
            OP_LDA, OP_STA:                         end_step = S3;
            OP_ADD, OP_SUB:                         end_step = S4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
            OP_HLT:                                 end_step = S2;
            default:                                end_step = S1;
        endcase
    end

    // HLT parks with the counter frozen at T2; only reset leaves HALTED.
    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        if (mode_q == RUN && bus.step_en) begin
            if (bus.opcode == OP_HLT && step_q == S2) begin
                mode_d = HALTED;
            end else if (step_q == end_step || step_q >= S_LAST) begin
                step_d = S0;
            end else begin
                step_d = step_q + S1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= RUN;
            step_q <= S0;
        end else begin
            mode_q <= mode_d;
            step_q <= step_d;
        end
    end

    logic co, j, ce, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, hlt;

    always_comb begin
        {co, j, ce, mi, ri, ro, ii, io, ai, ao, bi, eo, su, fi, oi, hlt} = '0;
        if (!rst && mode_q == RUN) begin
            unique case (step_q)
                S0: begin co = 1'b1; mi = 1'b1; end
                S1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
                S2: begin
                    unique case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io = 1'b1; mi = 1'b1; end
                        OP_LDI: begin io = 1'b1; ai = 1'b1; end
                        OP_JMP: begin io = 1'b1; j = 1'b1; end
                        OP_JC:  begin io = bus.cf; j = bus.cf; end
                        OP_JZ:  begin io = bus.zf; j = bus.zf; end
                        OP_OUT: begin ao = 1'b1; oi = 1'b1; end
                        OP_HLT: hlt = 1'b1;
                        default: ;
                    endcase
                end
                S3: begin
                    unique case (bus.opcode)
                        OP_LDA:         begin ro = 1'b1; ai = 1'b1; end
                        OP_ADD, OP_SUB: begin ro = 1'b1; bi = 1'b1; end
                        OP_STA:         begin ao = 1'b1; ri = 1'b1; end
                        default: ;
                    endcase
                end
                S4: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        eo = 1'b1; ai = 1'b1; fi = 1'b1;
                        su = (bus.opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
        if (!rst && mode_q == HALTED) hlt = 1'b1;
    end

    assign bus.step   = step_q;
    assign bus.halted = (mode_q == HALTED);
    assign bus.hlt    = hlt;
    assign bus.co = co;  assign bus.j  = j;   assign bus.ce = ce;
    assign bus.mi = mi;  assign bus.ri = ri;  assign bus.ro = ro;
    assign bus.ii = ii;  assign bus.io = io;
    assign bus.ai = ai;  assign bus.ao = ao;  assign bus.bi = bi;
    assign bus.eo = eo;  assign bus.su = su;  assign bus.fi = fi;
    assign bus.oi = oi;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction runs plus random
// stimulus, compared every cycle against a microcode-table reference model.
module tb_control_sequencer;
  localparam int STEP_W = 3;
  localparam int LAST_STEP = 4;

  // control word bit positions: {hlt,co,j,ce,mi,ri,ro,ii,io,ai,ao,bi,eo,su,fi,oi}
  localparam int B_HLT = 15, B_CO = 14, B_J = 13, B_CE = 12, B_MI = 11, B_RI = 10,
                 B_RO = 9, B_II = 8, B_IO = 7, B_AI = 6, B_AO = 5, B_BI = 4,
                 B_EO = 3, B_SU = 2, B_FI = 1, B_OI = 0;

  logic clk;
  logic rst;

  control_sequencer_if #(.STEP_W(STEP_W)) bus ();

  control_sequencer #(.STEP_W(STEP_W), .LAST_STEP(LAST_STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: microcode ROM per opcode and instruction length
  logic [15:0] ucode [16][5];
  int          last_of [16];
  int          m_step;
  bit          m_halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] bit1(input int b);
    return 16'(1) << b;
  endfunction

  task automatic build_model();
    for (int op = 0; op < 16; op++) begin
      for (int s = 0; s < 5; s++) ucode[op][s] = '0;
      ucode[op][0] = bit1(B_CO) | bit1(B_MI);
      ucode[op][1] = bit1(B_RO) | bit1(B_II) | bit1(B_CE);
      last_of[op] = 1;
    end
    ucode[1][2] = bit1(B_IO) | bit1(B_MI); ucode[1][3] = bit1(B_RO) | bit1(B_AI); last_of[1] = 3;
    for (int op = 2; op <= 3; op++) begin
      ucode[op][2] = bit1(B_IO) | bit1(B_MI);
      ucode[op][3] = bit1(B_RO) | bit1(B_BI);
      ucode[op][4] = bit1(B_EO) | bit1(B_AI) | bit1(B_FI) | ((op == 3) ? bit1(B_SU) : 16'h0);
      last_of[op] = 4;
    end
    ucode[4][2] = bit1(B_IO) | bit1(B_MI); ucode[4][3] = bit1(B_AO) | bit1(B_RI); last_of[4] = 3;
    ucode[5][2] = bit1(B_IO) | bit1(B_AI); last_of[5] = 2;
    ucode[6][2] = bit1(B_IO) | bit1(B_J);  last_of[6] = 2;
    ucode[7][2] = bit1(B_IO) | bit1(B_J);  last_of[7] = 2;
    ucode[8][2] = bit1(B_IO) | bit1(B_J);  last_of[8] = 2;
    ucode[14][2] = bit1(B_AO) | bit1(B_OI); last_of[14] = 2;
    ucode[15][2] = bit1(B_HLT);             last_of[15] = 2;
  endtask

  function automatic logic [15:0] model_ctrl(input bit r, input logic [3:0] op, input bit c, input bit z);
    logic [15:0] w;
    if (r) return '0;
    if (m_halted) return bit1(B_HLT);
    w = ucode[op][m_step];
    if (m_step == 2 && ((op == 4'd7 && !c) || (op == 4'd8 && !z))) w = '0;
    return w;
  endfunction

  function automatic logic [15:0] dut_ctrl();
    return {bus.hlt, bus.co, bus.j, bus.ce, bus.mi, bus.ri, bus.ro, bus.ii, bus.io,
            bus.ai, bus.ao, bus.bi, bus.eo, bus.su, bus.fi, bus.oi};
  endfunction

  task automatic model_edge(input bit en, input logic [3:0] op);
    if (en && !m_halted) begin
      if (op == 4'd15 && m_step == 2) m_halted = 1'b1;
      else if (m_step >= last_of[op] || m_step >= LAST_STEP) m_step = 0;
      else m_step = m_step + 1;
    end
  endtask

  task automatic check_outputs(input bit r, input logic [3:0] op, input bit c, input bit z);
    logic [15:0] w;
    w = dut_ctrl();
    exp_q.push_back(32'(model_ctrl(r, op, c, z)));
    check("ctrl", 32'(w), exp_q.pop_front());
    check("step", 32'(bus.step), 32'(m_step));
    check("halted", 32'(bus.halted), 32'(m_halted));
    check("bus_one_hot", 32'($countones({bus.co, bus.ro, bus.io, bus.ao, bus.eo}) <= 1), 32'd1);
    check("ai_bi_excl", 32'(bus.ai & bus.bi), 32'd0);
  endtask

  // driver: apply inputs after an edge, check before the next edge, then advance the model
  task automatic cyc(input bit r, input bit en, input logic [3:0] op, input bit c, input bit z);
    rst = r;
    bus.step_en = en;
    bus.opcode = op;
    bus.cf = c;
    bus.zf = z;
    if (r) begin
      m_step = 0;
      m_halted = 1'b0;
    end
    #3;
    check_outputs(r, op, c, z);
    @(posedge clk);
    if (!r) model_edge(en, op);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input int n, input bit c, input bit z);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, op, c, z);
  endtask

  initial begin
    logic [3:0] cur_op;
    bit         r, en;

    build_model();
    m_step = 0;
    m_halted = 1'b0;
    rst = 1'b1;
    bus.step_en = 1'b1;
    bus.opcode = 4'd1;
    bus.cf = 1'b0;
    bus.zf = 1'b0;

    // reset, then LDA followed by the wrap to T0
    cyc(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    run_instr(4'd1, 4, 1'b0, 1'b0);
    check("lda_wrap_step", 32'(bus.step), 32'd0);
    run_instr(4'd2, 5, 1'b1, 1'b0);
    run_instr(4'd3, 5, 1'b0, 1'b1);

    // conditional jumps, both flag values
    run_instr(4'd7, 3, 1'b0, 1'b0);
    check("jc_nt_wrap", 32'(bus.step), 32'd0);
    run_instr(4'd7, 3, 1'b1, 1'b0);
    run_instr(4'd8, 3, 1'b0, 1'b0);
    run_instr(4'd8, 3, 1'b0, 1'b1);
    run_instr(4'd5, 3, 1'b0, 1'b0);
    run_instr(4'd6, 3, 1'b0, 1'b0);
    run_instr(4'd14, 3, 1'b0, 1'b0);
    run_instr(4'd0, 2, 1'b0, 1'b0);
    run_instr(4'd11, 2, 1'b0, 1'b0);

    // stall at T3 of ADD, then resume
    run_instr(4'd2, 3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd2, 1'b0, 1'b0);
    check("stall_bi", 32'(bus.bi & bus.ro), 32'd1);
    run_instr(4'd2, 2, 1'b0, 1'b0);

    // asynchronous reset mid-T3 of STA
    run_instr(4'd4, 3, 1'b0, 1'b0);
    check("sta_t3_ri", 32'(bus.ri), 32'd1);
    #2;
    rst = 1'b1;
    m_step = 0;
    m_halted = 1'b0;
    #1;
    check("async_rst_ctrl", 32'(dut_ctrl()), 32'd0);
    check("async_rst_step", 32'(bus.step), 32'd0);
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
    run_instr(4'd4, 4, 1'b0, 1'b0);

    // HLT parks the machine regardless of inputs
    run_instr(4'd15, 3, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("hlt_parked", 32'(bus.hlt), 32'd1);
    cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    check("hlt_cleared_step", 32'(bus.step), 32'd0);

    // random traffic; opcode only changes at T0 or while halted
    cur_op = 4'd1;
    for (int i = 0; i < 400; i++) begin
      if (m_step == 0 || m_halted) begin
        cur_op = 4'($urandom_range(0, 15));
        if (cur_op == 4'd15 && $urandom_range(0, 3) != 0) cur_op = 4'd2;
      end
      r  = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 3) != 0);
      cyc(r, en, cur_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
